// File: rtl/calc_pkg.sv
// calc_pkg: shared operator, builder state and key classification types
package calc_pkg;
  typedef enum logic [2:0] {NONE = 3'b000, NEG = 3'b001, ADD = 3'b010, SUB = 3'b011, MUL = 3'b100} op_t;
  typedef enum logic [2:0] {ENTER_A, ENTER_B, ISSUE, WAIT_RES, RESULT} builder_state_t;
  typedef enum logic [1:0] {DIGIT, OP, EQUAL} key_kind_t;
endpackage

// File: rtl/decimal_accum.sv
// decimal_accum: sign/magnitude decimal entry register for one signed operand
module decimal_accum #(
  parameter int MAX_MAG = 32767
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        clr,
  input  logic        dig_stb,
  input  logic [3:0]  digit,
  input  logic        neg_stb,
  input  logic        load_stb,
  input  logic [15:0] load_val,
  output logic [15:0] value,
  output logic        has_digit,
  output logic        ovf
);
  logic [14:0] mag, mag_b;
  logic        neg, neg_b, has_b, fits;
  logic [19:0] t;
  always_comb begin
    mag_b = clr ? '0 : mag;
    neg_b = clr ? 1'b0 : neg;
    has_b = clr ? 1'b0 : has_digit;
    t     = 20'(mag_b) * 20'd10 + 20'(digit);
    fits  = t <= 20'(MAX_MAG);
    ovf   = (dig_stb && !fits) || (load_stb && load_val == 16'h8000);
    value = neg ? -{1'b0, mag} : {1'b0, mag};
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      mag       <= '0;
      neg       <= 1'b0;
      has_digit <= 1'b0;
    end else if (load_stb) begin
      neg       <= load_val[15];
      mag       <= load_val == 16'h8000 ? 15'h7fff : load_val[15] ? 15'(-load_val) : load_val[14:0];
      has_digit <= 1'b1;
    end else begin
      mag       <= (dig_stb && fits) ? t[14:0] : mag_b;
      neg       <= neg_stb ? !neg_b : neg_b;
      has_digit <= has_b | (dig_stb && fits);
    end
  end
endmodule

// File: rtl/operand_builder.sv
// operand_builder: keypad events to ALU requests; OPERAND_RESULT_CHAIN_EN lets an operator continue from the result
module operand_builder
  import calc_pkg::*;
#(
  parameter int DEBUG_MAX_MAG = 32767
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        read_input,
  output logic        key_read,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [2:0]  op_code,
  output logic        calc_valid,
  input  logic        calc_ready,
  input  logic [15:0] res_in,
  input  logic        res_valid,
  output logic [15:0] disp_value,
  output logic        ovf_err
);
  builder_state_t state;
  key_kind_t      kind;
  logic        arm, acc, arith, is_neg, dig;
  logic        a_clr, a_dig, a_neg, a_load, b_clr, b_dig, b_neg;
  logic        ovf_a, ovf_b, b_has;
  logic [15:0] a_val, b_val, res;
  always_comb begin
    kind   = equal_input ? EQUAL : operator_input != NONE ? OP : DIGIT;
    acc    = read_input && arm && (state == ENTER_A || state == ENTER_B || state == RESULT);
    arith  = kind == OP && (operator_input == ADD || operator_input == SUB || operator_input == MUL);
    is_neg = kind == OP && operator_input == NEG;
    dig    = acc && kind == DIGIT;
    a_dig  = dig && (state == ENTER_A || state == RESULT);
    a_neg  = acc && is_neg && state == ENTER_A;
    b_dig  = dig && state == ENTER_B;
    b_neg  = acc && is_neg && state == ENTER_B;
`ifdef OPERAND_RESULT_CHAIN_EN
    a_clr  = dig && state == RESULT;
    a_load = acc && arith && state == RESULT;
    b_clr  = acc && arith && (state == ENTER_A || state == RESULT);
`else
    a_clr  = acc && state == RESULT && (kind == DIGIT || kind == EQUAL);
    a_load = 1'b0;
    b_clr  = acc && arith && state == ENTER_A;
`endif
    disp_value = state == ENTER_A ? a_val : state == ENTER_B ? b_val : state == RESULT ? res : op_b;
  end
  decimal_accum #(.MAX_MAG(DEBUG_MAX_MAG)) u_a (
    .clk(clk), .RST(RST), .clr(a_clr), .dig_stb(a_dig), .digit(keypad_input), .neg_stb(a_neg),
    .load_stb(a_load), .load_val(res), .value(a_val), .has_digit(), .ovf(ovf_a)
  );
  decimal_accum #(.MAX_MAG(DEBUG_MAX_MAG)) u_b (
    .clk(clk), .RST(RST), .clr(b_clr), .dig_stb(b_dig), .digit(keypad_input), .neg_stb(b_neg),
    .load_stb(1'b0), .load_val(16'd0), .value(b_val), .has_digit(b_has), .ovf(ovf_b)
  );
  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= ENTER_A;
      arm        <= 1'b0;
      key_read   <= 1'b0;
      calc_valid <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= NONE;
      res        <= '0;
      ovf_err    <= 1'b0;
    end else begin
      arm      <= !read_input ? 1'b1 : acc ? 1'b0 : arm;
      key_read <= acc;
      ovf_err  <= (ovf_a || ovf_b) ? 1'b1 : a_clr ? 1'b0 : ovf_err;
      case (state)
        ENTER_A: if (acc && arith) begin
          op_code <= operator_input;
          state   <= ENTER_B;
        end
        ENTER_B: if (acc && arith && !b_has) op_code <= operator_input;
          else if (acc && kind == EQUAL) begin
            op_a       <= a_val;
            op_b       <= b_val;
            calc_valid <= 1'b1;
            state      <= ISSUE;
          end
        ISSUE: if (calc_ready) begin
          calc_valid <= 1'b0;
          state      <= WAIT_RES;
        end
        WAIT_RES: if (res_valid) begin
          res   <= res_in;
          state <= RESULT;
        end
        RESULT: begin
          if (dig) state <= ENTER_A;
`ifdef OPERAND_RESULT_CHAIN_EN
          if (acc && arith) begin
            op_code <= operator_input;
            state   <= ENTER_B;
          end
          if (acc && is_neg) res <= -res;
`else
          if (acc && kind == EQUAL) state <= ENTER_A;
`endif
        end
        default: state <= ENTER_A;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_builder.sv
// tb_operand_builder: directed self-checking bench for operand_builder
module tb_operand_builder;
  logic        clk = 1'b0, RST = 1'b1, read_input = 1'b0, equal_input = 1'b0;
  logic        calc_ready = 1'b0, res_valid = 1'b0;
  logic [3:0]  keypad_input = '0;
  logic [2:0]  operator_input = '0;
  logic [15:0] res_in = '0;
  logic        key_read, calc_valid, ovf_err;
  logic [15:0] op_a, op_b, disp_value;
  logic [2:0]  op_code;
  int passed = 0, total = 0;
  operand_builder dut (
    .clk(clk), .RST(RST), .read_input(read_input), .key_read(key_read), .keypad_input(keypad_input),
    .operator_input(operator_input), .equal_input(equal_input), .op_a(op_a), .op_b(op_b),
    .op_code(op_code), .calc_valid(calc_valid), .calc_ready(calc_ready), .res_in(res_in),
    .res_valid(res_valid), .disp_value(disp_value), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  task automatic do_reset();
    RST = 1'b1; read_input = 1'b0; equal_input = 1'b0; operator_input = '0; keypad_input = '0;
    calc_ready = 1'b0; res_valid = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
  endtask
  task automatic press(input logic eq, input logic [2:0] op, input logic [3:0] d);
    int n;
    equal_input = eq; operator_input = op; keypad_input = d; read_input = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!key_read && n < 20);
    if (!key_read) begin
      total++;
      $display("FAIL press_timeout key eq=%0b op=%0d d=%0d got no key_read", eq, op, d);
    end
    read_input = 1'b0;
    @(negedge clk);
    equal_input = 1'b0; operator_input = '0;
  endtask
  task automatic give_result(input logic [15:0] v);
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0; res_in = v; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (key_read !== 1'b0 || calc_valid !== 1'b0) $display("FAIL reset_handshake got kr=%b cv=%b want 0 0", key_read, calc_valid); else passed++;
    total++; if (op_a !== 16'd0 || op_b !== 16'd0 || op_code !== 3'd0) $display("FAIL reset_ops got a=%h b=%h op=%0d want 0 0 0", op_a, op_b, op_code); else passed++;
    total++; if (disp_value !== 16'd0 || ovf_err !== 1'b0) $display("FAIL reset_disp got disp=%h ovf=%b want 0 0", disp_value, ovf_err); else passed++;
  endtask
  task automatic test_basic();
    do_reset();
    press(0, 0, 1); press(0, 0, 2); press(0, 0, 3);
    total++; if (disp_value !== 16'd123) $display("FAIL basic_disp_a got %0d want 123", $signed(disp_value)); else passed++;
    press(0, 3'b010, 0); press(0, 0, 4); press(0, 3'b011, 0); press(0, 0, 5);
    total++; if (disp_value !== 16'd45) $display("FAIL basic_disp_b got %0d want 45", $signed(disp_value)); else passed++;
    press(1, 0, 0);
    total++; if (calc_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", calc_valid); else passed++;
    total++; if (op_a !== 16'd123 || op_b !== 16'd45 || op_code !== 3'b010) $display("FAIL basic_req got a=%0d b=%0d op=%0d want 123 45 2", op_a, op_b, op_code); else passed++;
    res_in = 16'd999; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    total++; if (calc_valid !== 1'b1 || disp_value !== 16'd45) $display("FAIL basic_stray_res got cv=%b disp=%0d want 1 45", calc_valid, disp_value); else passed++;
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0;
    total++; if (calc_valid !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", calc_valid); else passed++;
    res_in = 16'd168; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    total++; if (disp_value !== 16'd168) $display("FAIL basic_result got %0d want 168", $signed(disp_value)); else passed++;
  endtask
  task automatic test_hold();
    int n;
    do_reset();
    keypad_input = 4'd7; read_input = 1'b1; n = 0;
    repeat (20) begin @(negedge clk); if (key_read) n++; end
    read_input = 1'b0;
    @(negedge clk);
    total++; if (n !== 1) $display("FAIL hold_pulses got %0d want 1", n); else passed++;
    total++; if (disp_value !== 16'd7) $display("FAIL hold_value got %0d want 7", $signed(disp_value)); else passed++;
  endtask
  task automatic test_overflow();
    do_reset();
    press(0, 0, 3); press(0, 0, 2); press(0, 0, 7); press(0, 0, 6); press(0, 0, 7);
    total++; if (disp_value !== 16'd32767 || ovf_err !== 1'b0) $display("FAIL ovf_edge got disp=%0d ovf=%b want 32767 0", disp_value, ovf_err); else passed++;
    press(0, 0, 9);
    total++; if (disp_value !== 16'd32767 || ovf_err !== 1'b1) $display("FAIL ovf_drop got disp=%0d ovf=%b want 32767 1", disp_value, ovf_err); else passed++;
    press(0, 3'b010, 0); press(1, 0, 0);
    total++; if (op_a !== 16'd32767 || op_b !== 16'd0 || ovf_err !== 1'b1) $display("FAIL ovf_req got a=%0d b=%0d ovf=%b want 32767 0 1", op_a, op_b, ovf_err); else passed++;
    give_result(16'd5);
    total++; if (ovf_err !== 1'b1 || disp_value !== 16'd5) $display("FAIL ovf_sticky got ovf=%b disp=%0d want 1 5", ovf_err, disp_value); else passed++;
    press(0, 0, 2);
    total++; if (ovf_err !== 1'b0 || disp_value !== 16'd2) $display("FAIL ovf_clear got ovf=%b disp=%0d want 0 2", ovf_err, disp_value); else passed++;
  endtask
  task automatic test_neg_mul();
    int kr, vc, n;
    do_reset();
    press(0, 0, 5); press(0, 3'b001, 0);
    total++; if (disp_value !== 16'hFFFB) $display("FAIL neg_disp got %0d want -5", $signed(disp_value)); else passed++;
    press(0, 3'b011, 0); press(0, 3'b100, 0); press(0, 0, 2); press(1, 0, 0);
    total++; if (op_a !== 16'hFFFB || op_b !== 16'd2 || op_code !== 3'b100) $display("FAIL neg_req got a=%h b=%h op=%0d want fffb 0002 4", op_a, op_b, op_code); else passed++;
    keypad_input = 4'd9; read_input = 1'b1; kr = 0; vc = 0;
    repeat (5) begin @(negedge clk); if (key_read) kr++; if (calc_valid) vc++; end
    total++; if (vc !== 5) $display("FAIL neg_valid_held got %0d want 5", vc); else passed++;
    calc_ready = 1'b1;
    @(negedge clk);
    calc_ready = 1'b0; if (key_read) kr++;
    res_in = 16'hFFF6; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0; if (key_read) kr++;
    total++; if (kr !== 0 || disp_value !== 16'hFFF6) $display("FAIL neg_refused got kr=%0d disp=%0d want 0 -10", kr, $signed(disp_value)); else passed++;
    n = 0;
    while (!key_read && n < 5) begin @(negedge clk); n++; end
    total++; if (key_read !== 1'b1) $display("FAIL neg_late_accept got %b want 1", key_read); else passed++;
    read_input = 1'b0;
    @(negedge clk);
    total++; if (disp_value !== 16'd9) $display("FAIL neg_late_value got %0d want 9", $signed(disp_value)); else passed++;
  endtask
  task automatic test_result_keys();
    do_reset();
    press(0, 0, 1); press(0, 3'b010, 0); press(0, 0, 1); press(1, 0, 0);
    give_result(16'hFFF6);
    total++; if (disp_value !== 16'hFFF6) $display("FAIL chain_result got %0d want -10", $signed(disp_value)); else passed++;
    press(0, 3'b010, 0);
`ifdef OPERAND_RESULT_CHAIN_EN
    total++; if (disp_value !== 16'd0 || op_code !== 3'b010) $display("FAIL chain_op got disp=%0d op=%0d want 0 2", $signed(disp_value), op_code); else passed++;
    press(0, 0, 3); press(1, 0, 0);
    total++; if (calc_valid !== 1'b1 || op_a !== 16'hFFF6 || op_b !== 16'd3) $display("FAIL chain_req got cv=%b a=%0d b=%0d want 1 -10 3", calc_valid, $signed(op_a), $signed(op_b)); else passed++;
`else
    press(0, 3'b001, 0);
    total++; if (disp_value !== 16'hFFF6) $display("FAIL chain_ignored got %0d want -10", $signed(disp_value)); else passed++;
    press(0, 0, 3); press(1, 0, 0);
    total++; if (calc_valid !== 1'b0 || disp_value !== 16'd3) $display("FAIL chain_off got cv=%b disp=%0d want 0 3", calc_valid, $signed(disp_value)); else passed++;
`endif
  endtask
  task automatic test_reset_issue();
    do_reset();
    press(0, 0, 1); press(0, 3'b010, 0); press(0, 0, 2); press(1, 0, 0);
    total++; if (calc_valid !== 1'b1) $display("FAIL rst_pre got %b want 1", calc_valid); else passed++;
    RST = 1'b1;
    @(negedge clk);
    total++; if (calc_valid !== 1'b0 || disp_value !== 16'd0 || op_a !== 16'd0 || op_code !== 3'd0) $display("FAIL rst_issue got cv=%b disp=%0d a=%0d op=%0d want 0 0 0 0", calc_valid, disp_value, op_a, op_code); else passed++;
    RST = 1'b0;
    @(negedge clk);
    press(0, 0, 4);
    total++; if (disp_value !== 16'd4) $display("FAIL rst_enter_a got %0d want 4", $signed(disp_value)); else passed++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_neg_mul();
    test_result_keys();
    test_reset_issue();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
